// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: bus request/response structs and arbiter enums.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dbus_arbiter_pkg;

  localparam int DBUS_AW = 64;
  localparam int DBUS_DW = 64;
  localparam int DBUS_SW = DBUS_DW / 8;

  // One data-bus request; size is log2 of the access width in bytes.
  typedef struct packed {
    logic               valid;
    logic [DBUS_AW-1:0] addr;
    logic [2:0]         size;
    logic [DBUS_SW-1:0] strobe;
    logic [DBUS_DW-1:0] data;
  } dbus_req_t;

  // Memory response; addr_ok is informational, data_ok completes the access.
  typedef struct packed {
    logic               addr_ok;
    logic               data_ok;
    logic [DBUS_DW-1:0] data;
  } dbus_resp_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {ARB_M0, ARB_M1} arb_id_t;

  // The requester that round-robin favours after `id` was served.
  function automatic arb_id_t arb_other(input arb_id_t id);
    return (id == ARB_M0) ? ARB_M1 : ARB_M0;
  endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundles the two requester ports and the memory port of the data-bus arbiter.
// Latency: n/a (wiring only).
// Backpressure: n/a; the arbiter side drives responses and the memory request.
interface dbus_arbiter_if;
  import dbus_arbiter_pkg::*;

  dbus_req_t  m0_req;
  dbus_resp_t m0_resp;
  dbus_req_t  m1_req;
  dbus_resp_t m1_resp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  // Arbiter view: consumes requests and the memory response.
  modport slave (
    input  m0_req,
    input  m1_req,
    input  dresp,
    output m0_resp,
    output m1_resp,
    output dreq
  );

  // Environment view: requesters plus memory model.
  modport master (
    output m0_req,
    output m1_req,
    output dresp,
    input  m0_resp,
    input  m1_resp,
    input  dreq
  );

endinterface

// File: rtl/dbus_arb_pick.sv
// Combinational winner select between two data-bus requesters.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is acted upon.
module dbus_arb_pick
  import dbus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic    v0,
  input  logic    v1,
  input  arb_id_t last_grant,
  output logic    any,
  output arb_id_t winner
);

  // Single requester wins outright; on a tie m0 wins under fixed priority,
  // otherwise the one not served last.
  always_comb begin
    any    = v0 | v1;
    winner = ARB_M0;
    if (v0 && v1) begin
      winner = FIXED_PRIO ? ARB_M0 : arb_other(last_grant);
    end else if (v1) begin
      winner = ARB_M1;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-requester data-bus arbiter: grants one master, latches its request, routes the response back.
// Latency: requester valid to dreq.valid is 1 cycle; response passes through combinationally.
// Backpressure: ungranted requester waits with valid held; one IDLE cycle between transactions.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  dbus_arbiter_if.slave bus,
  output logic          busy,
  output logic          timeout_err
);

  // Counter wide enough to hold TIMEOUT itself (saturation value).
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_t    state;
  arb_id_t       gnt_q;
  arb_id_t       last_grant;
  dbus_req_t     req_q;
  logic [CW-1:0] wd_cnt;

  logic          pick_any;
  arb_id_t       pick_winner;
  logic          wd_expire;

  dbus_req_t     dreq_o;
  dbus_resp_t    m0_resp_o;
  dbus_resp_t    m1_resp_o;

  dbus_arb_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .v0         (bus.m0_req.valid),
    .v1         (bus.m1_req.valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  // Watchdog fires on the last allowed BUSY cycle unless memory completes in it.
  always_comb begin
    wd_expire = 1'b0;
    if (TIMEOUT > 0) begin
      wd_expire = (wd_cnt == WD_LAST) && !bus.dresp.data_ok;
    end
  end

  // Arbiter FSM: grant and latch in IDLE, complete or abandon in BUSY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ARB_IDLE;
      gnt_q       <= ARB_M0;
      last_grant  <= ARB_M1;
      req_q       <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            req_q      <= (pick_winner == ARB_M0) ? bus.m0_req : bus.m1_req;
            gnt_q      <= pick_winner;
            last_grant <= pick_winner;
            wd_cnt     <= '0;
            state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus.dresp.data_ok) begin
            // Completion beats a coincident watchdog expiry.
            state <= ARB_IDLE;
          end else if (wd_expire) begin
            // Abandon the access; the requester never sees data_ok for it.
            timeout_err <= 1'b1;
            state       <= ARB_IDLE;
          end else if ((TIMEOUT > 0) && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state so reset clears them without a clock.
  always_comb begin
    dreq_o    = '0;
    m0_resp_o = '0;
    m1_resp_o = '0;
    if (state == ARB_BUSY) begin
      dreq_o       = req_q;
      dreq_o.valid = 1'b1;
      if (gnt_q == ARB_M0) begin
        m0_resp_o = bus.dresp;
      end else begin
        m1_resp_o = bus.dresp;
      end
    end
  end

  assign bus.dreq    = dreq_o;
  assign bus.m0_resp = m0_resp_o;
  assign bus.m1_resp = m1_resp_o;
  assign busy        = (state == ARB_BUSY);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: round-robin and fixed-priority instances side by side.
// Latency: checks sample 1 time unit after the falling edge, away from the active edge.
// Backpressure: memory responses are scripted per scenario.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  logic rr_busy, rr_terr, fp_busy, fp_terr;

  dbus_arbiter_if rr_bus ();
  dbus_arbiter_if fp_bus ();

  dbus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(8)) dut_rr (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (rr_bus.slave),
    .busy        (rr_busy),
    .timeout_err (rr_terr)
  );

  dbus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(8)) dut_fp (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (fp_bus.slave),
    .busy        (fp_busy),
    .timeout_err (fp_terr)
  );

  always #5 clk = ~clk;

  function automatic dbus_req_t mk_req(input logic [63:0] addr, input logic [2:0] size);
    dbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = size;
    r.strobe = 8'hFF;
    return r;
  endfunction

  task automatic clear_inputs();
    rr_bus.m0_req = '0;
    rr_bus.m1_req = '0;
    rr_bus.dresp  = '0;
    fp_bus.m0_req = '0;
    fp_bus.m1_req = '0;
    fp_bus.dresp  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #1;
    checks++; if (rr_bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid got=%0b exp=0", rr_bus.dreq.valid); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", rr_busy); end
    checks++; if (rr_bus.m0_resp !== '0) begin errors++; $display("FAIL reset_m0_resp got=%h exp=0", rr_bus.m0_resp); end
    checks++; if (rr_bus.m1_resp !== '0) begin errors++; $display("FAIL reset_m1_resp got=%h exp=0", rr_bus.m1_resp); end
    checks++; if (rr_terr !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%0b exp=0", rr_terr); end
    checks++; if (fp_bus.dreq !== '0) begin errors++; $display("FAIL reset_fp_dreq got=%h exp=0", fp_bus.dreq); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    rr_bus.m0_req = mk_req(64'h8000_0010, 3'd3);
    #1;
    checks++; if (rr_bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL single_dreq_same_cycle got=%0b exp=0", rr_bus.dreq.valid); end
    @(negedge clk); #1;
    checks++; if (rr_bus.dreq.valid !== 1'b1) begin errors++; $display("FAIL single_dreq_valid got=%0b exp=1", rr_bus.dreq.valid); end
    checks++; if (rr_bus.dreq.addr !== 64'h8000_0010) begin errors++; $display("FAIL single_addr got=%h exp=80000010", rr_bus.dreq.addr); end
    checks++; if (rr_bus.dreq.size !== 3'd3) begin errors++; $display("FAIL single_size got=%0d exp=3", rr_bus.dreq.size); end
    @(negedge clk); #1;
    checks++; if (rr_bus.m0_resp.data_ok !== 1'b0) begin errors++; $display("FAIL single_early_data_ok got=%0b exp=0", rr_bus.m0_resp.data_ok); end
    @(negedge clk);
    rr_bus.dresp.data_ok = 1'b1;
    rr_bus.dresp.data    = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    checks++; if (rr_bus.m0_resp.data_ok !== 1'b1) begin errors++; $display("FAIL single_m0_data_ok got=%0b exp=1", rr_bus.m0_resp.data_ok); end
    checks++; if (rr_bus.m0_resp.data !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL single_m0_data got=%h exp=deadbeefcafef00d", rr_bus.m0_resp.data); end
    checks++; if (rr_bus.m1_resp !== '0) begin errors++; $display("FAIL single_m1_resp got=%h exp=0", rr_bus.m1_resp); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (rr_bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL single_done_dreq got=%0b exp=0", rr_bus.dreq.valid); end
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_addr [4];
    logic        exp_m1   [4];
    exp_addr = '{64'h100, 64'h200, 64'h100, 64'h200};
    exp_m1   = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    rr_bus.m0_req = mk_req(64'h100, 3'd2);
    rr_bus.m1_req = mk_req(64'h200, 3'd2);
    #1;
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rr_start_idle got=%0b exp=0", rr_busy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (rr_bus.dreq.addr !== exp_addr[k]) begin errors++; $display("FAIL rr_grant%0d addr got=%h exp=%h", k, rr_bus.dreq.addr, exp_addr[k]); end
      @(negedge clk);
      rr_bus.dresp.data_ok = 1'b1;
      rr_bus.dresp.data    = 64'(k);
      #1;
      checks++; if (rr_bus.m1_resp.data_ok !== exp_m1[k]) begin errors++; $display("FAIL rr_resp%0d m1_data_ok got=%0b exp=%0b", k, rr_bus.m1_resp.data_ok, exp_m1[k]); end
      checks++; if (rr_bus.m0_resp.data_ok !== !exp_m1[k]) begin errors++; $display("FAIL rr_resp%0d m0_data_ok got=%0b exp=%0b", k, rr_bus.m0_resp.data_ok, !exp_m1[k]); end
      @(negedge clk);
      rr_bus.dresp = '0;
      #1;
      checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d busy got=%0b exp=0", k, rr_busy); end
    end
    clear_inputs();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    fp_bus.m0_req = mk_req(64'h300, 3'd3);
    fp_bus.m1_req = mk_req(64'h400, 3'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (fp_bus.dreq.addr !== 64'h300) begin errors++; $display("FAIL fp_grant%0d addr got=%h exp=300", k, fp_bus.dreq.addr); end
      @(negedge clk);
      fp_bus.dresp.data_ok = 1'b1;
      #1;
      checks++; if (fp_bus.m0_resp.data_ok !== 1'b1 || fp_bus.m1_resp.data_ok !== 1'b0) begin
        errors++; $display("FAIL fp_resp%0d got m0=%0b m1=%0b exp m0=1 m1=0", k, fp_bus.m0_resp.data_ok, fp_bus.m1_resp.data_ok);
      end
      @(negedge clk);
      fp_bus.dresp = '0;
    end
    clear_inputs();
  endtask

  task automatic test_latch();
    @(negedge clk);
    rr_bus.m1_req = mk_req(64'h1000, 3'd2);
    @(negedge clk); #1;
    checks++; if (rr_bus.dreq.addr !== 64'h1000) begin errors++; $display("FAIL latch_grant addr got=%h exp=1000", rr_bus.dreq.addr); end
    rr_bus.m1_req.addr = 64'h2000;
    #1;
    checks++; if (rr_bus.dreq.addr !== 64'h1000) begin errors++; $display("FAIL latch_after_change addr got=%h exp=1000", rr_bus.dreq.addr); end
    @(negedge clk);
    rr_bus.dresp.data_ok = 1'b1;
    #1;
    checks++; if (rr_bus.dreq.addr !== 64'h1000) begin errors++; $display("FAIL latch_at_done addr got=%h exp=1000", rr_bus.dreq.addr); end
    checks++; if (rr_bus.m1_resp.data_ok !== 1'b1 || rr_bus.m0_resp.data_ok !== 1'b0) begin
      errors++; $display("FAIL latch_resp got m0=%0b m1=%0b exp m0=0 m1=1", rr_bus.m0_resp.data_ok, rr_bus.m1_resp.data_ok);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    rr_bus.m0_req = mk_req(64'h600, 3'd3);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      checks++; if (rr_busy !== 1'b1 || rr_terr !== 1'b0) begin
        errors++; $display("FAIL wd_busy_cycle%0d got busy=%0b terr=%0b exp busy=1 terr=0", i, rr_busy, rr_terr);
      end
    end
    @(negedge clk);
    rr_bus.m0_req = '0;
    rr_bus.m1_req = mk_req(64'h700, 3'd3);
    #1;
    checks++; if (rr_busy !== 1'b0 || rr_terr !== 1'b1) begin
      errors++; $display("FAIL wd_expired got busy=%0b terr=%0b exp busy=0 terr=1", rr_busy, rr_terr);
    end
    @(negedge clk); #1;
    checks++; if (rr_bus.dreq.addr !== 64'h700 || rr_busy !== 1'b1) begin
      errors++; $display("FAIL wd_next_grant got addr=%h busy=%0b exp addr=700 busy=1", rr_bus.dreq.addr, rr_busy);
    end
    @(negedge clk);
    rr_bus.dresp.data_ok = 1'b1;
    #1;
    checks++; if (rr_bus.m1_resp.data_ok !== 1'b1) begin errors++; $display("FAIL wd_next_done got=%0b exp=1", rr_bus.m1_resp.data_ok); end
    checks++; if (rr_terr !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%0b exp=1", rr_terr); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rr_bus.m0_req = mk_req(64'h400, 3'd3);
    @(negedge clk);
    rr_bus.dresp.addr_ok = 1'b1;
    rr_bus.dresp.data    = 64'h55;
    #1;
    checks++; if (rr_bus.m0_resp.addr_ok !== 1'b1 || rr_busy !== 1'b1) begin
      errors++; $display("FAIL arst_pre got addr_ok=%0b busy=%0b exp 1 1", rr_bus.m0_resp.addr_ok, rr_busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (rr_bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL arst_dreq_valid got=%0b exp=0", rr_bus.dreq.valid); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%0b exp=0", rr_busy); end
    checks++; if (rr_bus.m0_resp !== '0 || rr_bus.m1_resp !== '0) begin errors++; $display("FAIL arst_resp got m0=%h m1=%h exp 0", rr_bus.m0_resp, rr_bus.m1_resp); end
    checks++; if (rr_terr !== 1'b0) begin errors++; $display("FAIL arst_timeout_err got=%0b exp=0", rr_terr); end
    @(negedge clk);
    clear_inputs();
    resetn = 1'b1;
    rr_bus.m1_req = mk_req(64'h500, 3'd3);
    @(negedge clk); #1;
    checks++; if (rr_busy !== 1'b1 || rr_bus.dreq.addr !== 64'h500) begin
      errors++; $display("FAIL arst_m1_grant got busy=%0b addr=%h exp 1 500", rr_busy, rr_bus.dreq.addr);
    end
    @(negedge clk);
    rr_bus.dresp.data_ok = 1'b1;
    #1;
    checks++; if (rr_bus.m1_resp.data_ok !== 1'b1 || rr_bus.m0_resp.data_ok !== 1'b0) begin
      errors++; $display("FAIL arst_m1_resp got m0=%0b m1=%0b exp m0=0 m1=1", rr_bus.m0_resp.data_ok, rr_bus.m1_resp.data_ok);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_wd_data_ok_at_expiry();
    do_reset();
    rr_bus.m0_req = mk_req(64'h800, 3'd3);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    rr_bus.dresp.data_ok = 1'b1;
    rr_bus.dresp.data    = 64'hABCD;
    #1;
    checks++; if (rr_bus.m0_resp.data_ok !== 1'b1 || rr_bus.m0_resp.data !== 64'hABCD) begin
      errors++; $display("FAIL wdtie_resp got ok=%0b data=%h exp ok=1 data=abcd", rr_bus.m0_resp.data_ok, rr_bus.m0_resp.data);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (rr_terr !== 1'b0) begin errors++; $display("FAIL wdtie_timeout_err got=%0b exp=0", rr_terr); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL wdtie_busy got=%0b exp=0", rr_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_prio();
    test_latch();
    test_watchdog();
    test_async_reset();
    test_wd_data_ok_at_expiry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit reached got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-requester arbiter/sequencer for the single data bus (dbus_req_t / dbus_resp_t).
- Sits between the core's load/store stage (m0) and a second data-side master (m1, e.g. page-table walker or debug port) on one side, and the memory interface on the other.
- Grants one requester at a time and latches its request for the life of the transaction. Routes the response back only to the granted requester. Flags transactions that never complete.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0/m1; 1 = m0 always wins a tie.
- TIMEOUT, 1024: cycles in BUSY without dresp.data_ok before the timeout flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_req  in  dbus_req_t  request from requester 0.
- m0_resp  out  dbus_resp_t  response to requester 0.
- m1_req  in  dbus_req_t  request from requester 1.
- m1_resp  out  dbus_resp_t  response to requester 1.
- dreq  out  dbus_req_t  request to memory.
- dresp  in  dbus_resp_t  response from memory.
- busy  out  1  high while state is BUSY.
- timeout_err  out  1  sticky; set when the watchdog expires.

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - state=IDLE, last_grant=M1 (so m0 wins the first tie), all latched-request fields 0, watchdog count 0, timeout_err 0.
  - dreq.valid=0, m0_resp/m1_resp all-zero, busy=0.
  - All of these take effect immediately on resetn low, without waiting for a clock edge.
- Requester protocol: a requester raises valid and holds valid, addr, size, strobe and data stable until its own data_ok pulse. The arbiter does not rely on this stability after grant, because the request is latched.
- States:
  - IDLE: dreq.valid=0, both resps zero.
    - Neither valid: stay in IDLE.
    - Exactly one valid: grant that requester.
    - Both valid: if FIXED_PRIO=1, grant m0; otherwise grant the requester that is not last_grant.
    - On grant, at the clock edge: latch the winner's full request into req_q, set gnt_q and last_grant to the winner, clear the watchdog, go to BUSY.
  - BUSY:
    - dreq = req_q with valid=1; this is combinational from state, so latency from requester valid to dreq.valid is 1 cycle.
    - The granted requester's resp = dresp (addr_ok, data_ok, data passed through combinationally). The other requester's resp = all-zero.
    - dresp.addr_ok does not change state.
    - dresp.data_ok=1: go to IDLE at that edge, so dreq.valid drops on the next cycle.
    - Minimum turnaround is one IDLE cycle between transactions. A granted requester that immediately re-requests is treated normally in IDLE; round-robin then favours the other requester if it is waiting.
- Watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle without data_ok. It saturates at TIMEOUT and clears on grant.
  - When the count reaches TIMEOUT-1 with no data_ok, timeout_err is set at that edge.
  - After setting timeout_err, state is forced to IDLE and the granted requester receives no data_ok; the transaction is abandoned.
  - timeout_err clears only on reset.
- Simultaneous events:
  - data_ok in the same cycle as the other requester raising valid: complete to IDLE first; the grant happens in the following cycle.
  - data_ok in the same cycle as watchdog expiry: data_ok wins; timeout_err stays 0.
- Reset mid-transaction: resetn low drops dreq.valid asynchronously. The in-flight memory access is abandoned; discarding its late data_ok is the memory side's responsibility.
- Ungranted requester: dresp activity is never reflected to it; its resp stays zero for the entire BUSY period.

Decomposition:
- common package additions:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
  - typedef enum logic {ARB_M0, ARB_M1} arb_id_t.
- Sub-module dbus_arb_pick: combinational winner select.
  - Inputs: v0, v1, last_grant, FIXED_PRIO.
  - Outputs: any, winner.
  - Unit-testable in isolation.
- All state, the latch and the watchdog live in dbus_arbiter.

Test Plan:
- Single requester: m0 reads at addr=0x80000010, size=3, memory gives data_ok after 3 cycles with data=0xDEADBEEF_CAFEF00D -> dreq.valid asserted 1 cycle after m0 valid; m0_resp.data_ok pulses with that data; m1_resp stays 0.
- Tie, round-robin (FIXED_PRIO=0): m0 and m1 both valid from reset, each completing with 2-cycle latency -> grant order m0, m1, m0, m1; one IDLE cycle between each transaction.
- Tie, FIXED_PRIO=1: both requesters continuously valid -> m0 granted every time; m1 never granted (starvation is intended).
- Latch integrity: m1 changes addr from 0x1000 to 0x2000 one cycle after grant -> dreq.addr stays 0x1000 until data_ok.
- Watchdog: TIMEOUT=8, memory never asserts data_ok -> timeout_err set after 8 BUSY cycles, state returns to IDLE, next request is granted normally; a separate run with data_ok on exactly the expiry cycle -> timeout_err remains 0.
- Async reset mid-BUSY: resetn low between clock edges -> dreq.valid, busy, m0_resp/m1_resp and timeout_err go 0 before the next edge; after release, m1 alone valid is granted.
